mac_group_acc: RTL and testbench

//  Downstream consumer of the pipelined multiply-add stage (DATA_OUT = A*B+C, 3-clock latency).

---
 rtl/mac_group_acc_pkg.sv | 15 +
 rtl/mac_group_acc_if.sv | 27 ++
 rtl/mac_group_acc_sum_fifo.sv | 60 ++++++
 rtl/mac_group_acc.sv | 117 +++++++++++
 tb/tb_mac_group_acc.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_group_acc_pkg.sv
// Parameters shared by the multiply-add stage and its downstream group accumulator.
// The accumulator width also fixes the type of each group sum.
package mac_group_acc_pkg;
    localparam int DATA_OUT_size = 16;
    localparam int MAC_LATENCY   = 3;
    localparam int ACC_size      = 24;
    localparam int FIFO_DEPTH    = 4;

    typedef logic [ACC_size-1:0] acc_t;

    // Occupancy counters need one extra bit so that "full" can be represented.
    function automatic int countWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/mac_group_acc_if.sv
// Bundle of MAC-result inputs and group-sum output signals for mac_group_acc.
// The master modport is the accumulator side; the slave modport is the producer/consumer side.
interface mac_group_acc_if import mac_group_acc_pkg::*; #(
    parameter int IN_W  = DATA_OUT_size,
    parameter int ACC_W = ACC_size,
    parameter int DEPTH = FIFO_DEPTH
);
    logic                   op_valid;
    logic [IN_W-1:0]        mac_data;
    logic                   clear;
    logic [ACC_W-1:0]       out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   sat_flag;
    logic                   drop_flag;

    modport master (
        input  op_valid, mac_data, clear, out_ready,
        output out_data, out_valid, fifo_count, sat_flag, drop_flag
    );

    modport slave (
        output op_valid, mac_data, clear, out_ready,
        input  out_data, out_valid, fifo_count, sat_flag, drop_flag
    );
endinterface

// File: rtl/mac_group_acc_sum_fifo.sv
// Small FIFO for completed group sums; head is shown combinationally and reads as 0 when empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module mac_group_acc_sum_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 24
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [W-1:0]           pushData,
    input  logic                   pop,
    output logic [W-1:0]           headData,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             pushOk;
    logic             popOk;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign popOk    = pop & ~empty;
    assign pushOk   = push & (~full | popOk);
    assign headData = empty ? '0 : mem[rdPtr];

    always_ff @(posedge clock) begin
        if (pushOk) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushOk) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
            if (popOk) begin
                rdPtr <= rdPtr + PTR_ONE;
            end
            if (pushOk && !popOk) begin
                count <= count + CNT_ONE;
            end else if (!pushOk && popOk) begin
                count <= count - CNT_ONE;
            end
        end
    end
endmodule

// File: rtl/mac_group_acc.sv
// Qualifies MAC results with a latency-matched valid delay line, sums groups of GROUP_LEN
// results into a saturating accumulator and queues finished sums for a valid/ready consumer.
module mac_group_acc import mac_group_acc_pkg::*; #(
    parameter int MAC_LAT   = MAC_LATENCY,
    parameter int IN_W      = DATA_OUT_size,
    parameter int ACC_W     = ACC_size,
    parameter int GROUP_LEN = 4,
    parameter int DEPTH     = FIFO_DEPTH
) (
    input  logic            clock,
    input  logic            reset_n,
    mac_group_acc_if.master bus
);
    localparam logic [7:0] LAST_IDX = 8'(GROUP_LEN - 1);

    logic [MAC_LAT-1:0]     vldDly;
    logic [ACC_W-1:0]       accReg;
    logic [ACC_W-1:0]       accNext;
    logic [ACC_W-1:0]       accBase;
    logic [7:0]             grpCnt;
    logic [7:0]             grpNext;
    logic [7:0]             grpBase;
    logic                   satFlag;
    logic                   satNext;
    logic                   dropFlag;
    logic                   dropNext;
    logic                   sampleQual;
    logic [ACC_W:0]         sumWide;
    logic [ACC_W-1:0]       sumClamp;
    logic                   sumOvf;
    logic                   pushReq;
    logic                   popReq;
    logic                   fifoFull;
    logic                   fifoEmpty;
    logic [ACC_W-1:0]       fifoHead;
    logic [$clog2(DEPTH):0] fifoCount;

    // Valid tag travels alongside the MAC pipeline so its tail lines up with mac_data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vldDly <= '0;
        end else begin
            vldDly[0] <= bus.op_valid;
            for (int i = 1; i < MAC_LAT; i++) begin
                vldDly[i] <= vldDly[i-1];
            end
        end
    end

    assign sampleQual = vldDly[MAC_LAT-1];
    assign popReq     = ~fifoEmpty & bus.out_ready;

    // A same-cycle clear restarts from an empty group, so the sample opens a fresh group.
    always_comb begin
        accBase  = bus.clear ? '0 : accReg;
        grpBase  = bus.clear ? '0 : grpCnt;
        sumWide  = {1'b0, accBase} + (ACC_W+1)'(bus.mac_data);
        sumOvf   = sumWide[ACC_W];
        sumClamp = sumOvf ? '1 : sumWide[ACC_W-1:0];
        accNext  = accBase;
        grpNext  = grpBase;
        satNext  = bus.clear ? 1'b0 : satFlag;
        pushReq  = 1'b0;
        if (sampleQual) begin
            if (sumOvf) begin
                satNext = 1'b1;
            end
            if (grpBase == LAST_IDX) begin
                pushReq = 1'b1;
                accNext = '0;
                grpNext = '0;
            end else begin
                accNext = sumClamp;
                grpNext = grpBase + 8'd1;
            end
        end
        dropNext = bus.clear ? 1'b0 : dropFlag;
        if (pushReq && fifoFull && !popReq) begin
            dropNext = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            accReg   <= '0;
            grpCnt   <= '0;
            satFlag  <= 1'b0;
            dropFlag <= 1'b0;
        end else begin
            accReg   <= accNext;
            grpCnt   <= grpNext;
            satFlag  <= satNext;
            dropFlag <= dropNext;
        end
    end

    mac_group_acc_sum_fifo #(
        .DEPTH (DEPTH),
        .W     (ACC_W)
    ) sum_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (pushReq),
        .pushData (sumClamp),
        .pop      (popReq),
        .headData (fifoHead),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifoCount)
    );

    assign bus.out_data   = fifoHead;
    assign bus.out_valid  = ~fifoEmpty;
    assign bus.fifo_count = fifoCount;
    assign bus.sat_flag   = satFlag;
    assign bus.drop_flag  = dropFlag;
endmodule

// File: tb/tb_mac_group_acc.sv
// Randomized scoreboard bench: three accumulator configurations share one MAC-result stream
// and are compared against a queue-based reference model of group summing and FIFO buffering.
module tb_mac_group_acc;
    localparam int NI = 3;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    logic        opValid = 1'b0;
    logic [15:0] macData = '0;
    logic        clr     = 1'b0;
    bit          macQual = 1'b0;
    bit          ready [NI];
    int          rdyMode = 0;

    mac_group_acc_if #(.IN_W(16), .ACC_W(24), .DEPTH(4)) bus0 ();
    mac_group_acc_if #(.IN_W(16), .ACC_W(24), .DEPTH(4)) bus1 ();
    mac_group_acc_if #(.IN_W(16), .ACC_W(16), .DEPTH(4)) bus2 ();

    assign bus0.op_valid = opValid;  assign bus1.op_valid = opValid;  assign bus2.op_valid = opValid;
    assign bus0.mac_data = macData;  assign bus1.mac_data = macData;  assign bus2.mac_data = macData;
    assign bus0.clear    = clr;      assign bus1.clear    = clr;      assign bus2.clear    = clr;
    assign bus0.out_ready = ready[0];
    assign bus1.out_ready = ready[1];
    assign bus2.out_ready = ready[2];

    mac_group_acc #(.MAC_LAT(3), .IN_W(16), .ACC_W(24), .GROUP_LEN(4), .DEPTH(4)) dut0 (
        .clock(clock), .reset_n(reset_n), .bus(bus0.master));
    mac_group_acc #(.MAC_LAT(3), .IN_W(16), .ACC_W(24), .GROUP_LEN(1), .DEPTH(4)) dut1 (
        .clock(clock), .reset_n(reset_n), .bus(bus1.master));
    mac_group_acc #(.MAC_LAT(3), .IN_W(16), .ACC_W(16), .GROUP_LEN(2), .DEPTH(4)) dut2 (
        .clock(clock), .reset_n(reset_n), .bus(bus2.master));

    logic [23:0] outData  [NI];
    logic        outValid [NI];
    logic [2:0]  fifoCnt  [NI];
    logic        satF     [NI];
    logic        dropF    [NI];

    assign outData[0] = bus0.out_data;
    assign outData[1] = bus1.out_data;
    assign outData[2] = {8'h00, bus2.out_data};
    assign outValid[0] = bus0.out_valid;  assign outValid[1] = bus1.out_valid;  assign outValid[2] = bus2.out_valid;
    assign fifoCnt[0]  = bus0.fifo_count; assign fifoCnt[1]  = bus1.fifo_count; assign fifoCnt[2]  = bus2.fifo_count;
    assign satF[0]     = bus0.sat_flag;   assign satF[1]     = bus1.sat_flag;   assign satF[2]     = bus2.sat_flag;
    assign dropF[0]    = bus0.drop_flag;  assign dropF[1]    = bus1.drop_flag;  assign dropF[2]    = bus2.drop_flag;

    // Reference model: per configuration, running sum, samples in the current group,
    // sticky flags, and the list of sums held in the output buffer.
    int              glen   [NI] = '{4, 1, 2};
    longint unsigned accMax [NI] = '{64'hFF_FFFF, 64'hFF_FFFF, 64'hFFFF};
    localparam int   DEPTH = 4;
    longint unsigned mAcc  [NI];
    int              mGrp  [NI];
    bit              mSat  [NI];
    bit              mDrop [NI];
    longint unsigned mFifo [NI][$];
    longint unsigned sbQ   [NI][$];

    // Upstream MAC: results emerge three edges after their operands.
    bit          pV [3];
    logic [15:0] pD [3];

    int checks = 0;
    int errors = 0;

    function automatic logic [15:0] mac(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return 16'({8'd0, a} * {8'd0, b} + {8'd0, c});
    endfunction

    task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d at %0t: got %0h, expected %0h", name, inst, $time, act, exp);
        end
    endtask

    task automatic modelClear();
        for (int i = 0; i < NI; i++) begin
            mAcc[i] = 0; mGrp[i] = 0; mSat[i] = 0; mDrop[i] = 0;
            mFifo[i].delete();
            sbQ[i].delete();
        end
    endtask

    // Applies the effect of the clock edge that just happened, using the inputs held across it.
    task automatic modelEdge();
        for (int i = 0; i < NI; i++) begin
            bit pop;
            bit push;
            longint unsigned s;
            pop  = (mFifo[i].size() > 0) && ready[i];
            push = 0;
            s    = 0;
            if (clr) begin
                mAcc[i] = 0; mGrp[i] = 0; mSat[i] = 0; mDrop[i] = 0;
            end
            if (macQual) begin
                s = mAcc[i] + longint'(macData);
                if (s > accMax[i]) begin
                    s = accMax[i];
                    mSat[i] = 1;
                end
                if (mGrp[i] + 1 == glen[i]) begin
                    push = 1; mAcc[i] = 0; mGrp[i] = 0;
                end else begin
                    mAcc[i] = s; mGrp[i]++;
                end
            end
            if (pop) void'(mFifo[i].pop_front());
            if (push) begin
                if (mFifo[i].size() >= DEPTH) mDrop[i] = 1;
                else begin
                    mFifo[i].push_back(s);
                    sbQ[i].push_back(s);
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        if (!reset_n) modelClear();
        else modelEdge();
    endtask

    task automatic cyc(input bit v, input logic [15:0] val, input bit c);
        macQual = pV[2];
        macData = pV[2] ? pD[2] : 16'($urandom);
        pV[2] = pV[1]; pD[2] = pD[1];
        pV[1] = pV[0]; pD[1] = pD[0];
        pV[0] = v;     pD[0] = val;
        opValid = v;
        clr     = c;
        for (int i = 0; i < NI; i++) begin
            ready[i] = (rdyMode == 2) ? bit'($urandom_range(0, 1)) : (rdyMode == 1);
        end
        step();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 16'h0, 1'b0);
    endtask

    task automatic doReset(input int n);
        reset_n = 1'b0;
        opValid = 1'b0; clr = 1'b0; macQual = 1'b0;
        for (int i = 0; i < 3; i++) pV[i] = 0;
        modelClear();
        repeat (n) step();
        reset_n = 1'b1;
    endtask

    // Monitor: compares status every cycle and the head against the scoreboard on each pop.
    initial begin
        forever begin
            @(negedge clock);
            for (int i = 0; i < NI; i++) begin
                chk("out_valid", i, 64'(outValid[i]), 64'(mFifo[i].size() > 0));
                chk("fifo_count", i, 64'(fifoCnt[i]), 64'(mFifo[i].size()));
                chk("sat_flag", i, 64'(satF[i]), 64'(mSat[i]));
                chk("drop_flag", i, 64'(dropF[i]), 64'(mDrop[i]));
                if (sbQ[i].size() == 0) begin
                    chk("out_data_empty", i, 64'(outData[i]), 64'd0);
                end else begin
                    chk("out_data", i, 64'(outData[i]), sbQ[i][0]);
                    if (outValid[i] && ready[i]) begin
                        $display("pop inst%0d data=%0h expected=%0h t=%0t", i, outData[i], sbQ[i][0], $time);
                        void'(sbQ[i].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin pV[i] = 0; pD[i] = '0; end
        for (int i = 0; i < NI; i++) ready[i] = 0;
        modelClear();
        #1;
        // Reset held two clocks, then quiet.
        doReset(2);
        rdyMode = 0;
        idle(5);

        // One full group of 17s.
        repeat (4) cyc(1'b1, mac(8'd3, 8'd4, 8'd5), 1'b0);
        idle(6);
        rdyMode = 1; idle(6); rdyMode = 0;

        // Single-op latency with junk on mac_data in unqualified cycles.
        cyc(1'b1, mac(8'd2, 8'd3, 8'd1), 1'b0);
        idle(6);
        rdyMode = 1; idle(6); rdyMode = 0;

        // Overfill, then a push that coincides with a pop on a full FIFO.
        cyc(1'b0, 16'h0, 1'b1);
        for (int g = 0; g < 5; g++) begin
            repeat (4) cyc(1'b1, mac(8'($urandom), 8'($urandom), 8'($urandom)), 1'b0);
        end
        idle(4);
        repeat (4) cyc(1'b1, 16'(100 + $urandom_range(0, 50)), 1'b0);
        idle(2);
        rdyMode = 1; idle(1); rdyMode = 0;
        idle(2);
        rdyMode = 1; idle(8); rdyMode = 0;

        // Saturation, then clear drops the sticky flags.
        cyc(1'b0, 16'h0, 1'b1);
        repeat (4) cyc(1'b1, 16'hFFFF, 1'b0);
        idle(5);
        cyc(1'b0, 16'h0, 1'b1);
        rdyMode = 1; idle(6); rdyMode = 0;

        // Partial group discarded by clear, then by reset.
        repeat (2) begin
            cyc(1'b1, 16'd10, 1'b0);
            cyc(1'b1, 16'd20, 1'b0);
            idle(4);
            cyc(1'b0, 16'h0, 1'b1);
            repeat (4) cyc(1'b1, 16'd1, 1'b0);
            idle(5);
            rdyMode = 1; idle(6); rdyMode = 0;
        end
        cyc(1'b1, 16'd10, 1'b0);
        cyc(1'b1, 16'd20, 1'b0);
        idle(4);
        doReset(1);
        repeat (4) cyc(1'b1, 16'd1, 1'b0);
        idle(5);
        rdyMode = 1; idle(6);

        // Random traffic with sporadic clears, resets and back-pressure.
        rdyMode = 2;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                doReset(1);
            end else begin
                logic [15:0] v;
                v = ($urandom_range(0, 9) == 0) ? 16'hFFFF
                                                : mac(8'($urandom), 8'($urandom), 8'($urandom));
                cyc(bit'($urandom_range(0, 9) < 7), v, bit'($urandom_range(0, 39) == 0));
            end
        end
        rdyMode = 1;
        idle(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
